// File: rtl/pcs_gearbox_tx.sv
// rtl/pcs_gearbox_tx.sv - 66b-to-32b TX gearbox for the 10GBASE-R PCS
// Optional feature macro: PCS_GEARBOX_TX_HDR_CHECK_EN adds hdr_err_o, a
// one-cycle flag for an invalid sync header (2'b00 or 2'b11).
module pcs_gearbox_tx #(
  parameter int DATA_W = 32,
  parameter int HEAD_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
`ifdef PCS_GEARBOX_TX_HDR_CHECK_EN
  ,
  output logic              hdr_err_o
`endif
);

  // One period is 32 accepted beats (16 blocks) followed by one flush slot.
  localparam logic [5:0] SEQ_FLUSH = 6'd32;
  localparam logic [5:0] FILL_STEP = 6'd2;
  // The packing window is 64 bits wide: an even beat (34 bits) only ever
  // lands on fill <= 30 and an odd beat (32 bits) on fill <= 32, so the
  // combined vector never reaches past bit 63.
  localparam int COMB_W = 2 * DATA_W;

  logic [5:0]        seq_q, seq_d;
  logic              half_q, half_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [5:0]        fill_q, fill_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              accept;
  logic              flush;
  logic [DATA_W+HEAD_W-1:0] push_bits;
  logic [COMB_W-1:0] push_ext;
  logic [COMB_W-1:0] keep_mask;
  logic [COMB_W-1:0] buf_ext;
  logic [COMB_W-1:0] comb;

  assign ready_o = (seq_q != SEQ_FLUSH);
  assign flush   = (seq_q == SEQ_FLUSH);
  assign accept  = valid_i & ready_o;

  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Even beats carry the header in the lowest bits ahead of the payload;
  // odd beats carry only the second payload half.
  always_comb begin
    push_bits = '0;
    if (half_q) begin
      push_bits = {{HEAD_W{1'b0}}, data_i};
    end else begin
      push_bits = {data_i, head_i};
    end
  end

  // Leftover bits sit below the new bits; the new bits are shifted up by fill.
  always_comb begin
    push_ext  = {{(COMB_W-DATA_W-HEAD_W){1'b0}}, push_bits} << fill_q;
    keep_mask = ~({COMB_W{1'b1}} << fill_q);
    buf_ext   = {{(COMB_W-DATA_W){1'b0}}, buf_q} & keep_mask;
    comb      = push_ext | buf_ext;
  end

  // Next-state for the sequencer, leftover buffer and output word.
  always_comb begin
    seq_d   = seq_q;
    half_d  = half_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    data_d  = data_q;
    if (flush) begin
      // Sixteen headers have accumulated exactly one full word of leftover.
      data_d  = buf_q;
      valid_d = 1'b1;
      buf_d   = '0;
      fill_d  = '0;
      seq_d   = '0;
    end else if (accept) begin
      data_d  = comb[DATA_W-1:0];
      valid_d = 1'b1;
      buf_d   = comb[COMB_W-1:DATA_W];
      fill_d  = half_q ? fill_q : (fill_q + FILL_STEP);
      seq_d   = seq_q + 6'd1;
      half_d  = ~half_q;
    end
  end

  // State and registered output; reset discards any partial block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q   <= '0;
      half_q  <= 1'b0;
      buf_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      seq_q   <= seq_d;
      half_q  <= half_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef PCS_GEARBOX_TX_HDR_CHECK_EN
  logic hdr_err_q, hdr_err_d;

  // Flag 00/11 headers on accepted even beats; the data path is untouched.
  always_comb begin
    hdr_err_d = accept & ~half_q & (head_i[0] == head_i[1]);
  end

  // Register the flag so it lines up with the word carrying the header.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_err_q <= 1'b0;
    end else begin
      hdr_err_q <= hdr_err_d;
    end
  end

  assign hdr_err_o = hdr_err_q;
`endif

endmodule

// File: tb/tb_pcs_gearbox_tx.sv
// tb/tb_pcs_gearbox_tx.sv - directed and table-driven bench for pcs_gearbox_tx
module tb_pcs_gearbox_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [1:0]  head_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
`ifdef PCS_GEARBOX_TX_HDR_CHECK_EN
  logic        hdr_err_o;
`endif

  always #5 clk = ~clk;

  pcs_gearbox_tx #(.DATA_W(32), .HEAD_W(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o)
`ifdef PCS_GEARBOX_TX_HDR_CHECK_EN
    ,
    .hdr_err_o (hdr_err_o)
`endif
  );

  typedef struct {
    logic        v;
    logic [1:0]  h;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        er;
  } vec_t;

  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] words[$];

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] blk_lo(input int k);
    return 32'hA500_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] blk_hi(input int k);
    return 32'h5A00_0000 | (32'(k) << 8);
  endfunction

  function automatic logic [1:0] blk_head(input int k);
    return (k % 2 == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset;
    valid_i = 1'b0;
    head_i  = 2'b00;
    data_i  = 32'h0;
    reset   = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_data",  data_o,  32'h0);
    check("rst_ready", ready_o, 1'b1);
`ifdef PCS_GEARBOX_TX_HDR_CHECK_EN
    check("rst_hdr_err", hdr_err_o, 1'b0);
`endif
    reset = 1'b0;
  endtask

  initial begin
    int          bseq;
    int          beat;
    int          zeros;
    logic        exp_v;
    logic [65:0] got;
    logic [65:0] exp_blk;
    int          pos;

    reset   = 1'b1;
    valid_i = 1'b0;
    head_i  = 2'b00;
    data_i  = 32'h0;

    // Hand-packed first beats after reset: fill goes 0,2,2,2,4,4,6.
    vecs[0] = '{1'b1, 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0};
    vecs[1] = '{1'b1, 2'b10, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0003, 1'b0};
    vecs[2] = '{1'b0, 2'b11, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 2'b10, 32'h1234_5678, 1'b1, 1'b1, 32'h2345_6788, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 32'hABCD_EF01, 1'b1, 1'b1, 32'hBCDE_F011, 1'b0};
    vecs[5] = '{1'b1, 2'b11, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_003A, 1'b1};
    vecs[6] = '{1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0};

    do_reset;
    for (int i = 0; i < 7; i++) begin
      valid_i = vecs[i].v;
      head_i  = vecs[i].h;
      data_i  = vecs[i].d;
      check($sformatf("vec%0d_ready", i), ready_o, vecs[i].rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), valid_o, vecs[i].ev);
      if (vecs[i].ev) check($sformatf("vec%0d_data", i), data_o, vecs[i].ed);
`ifdef PCS_GEARBOX_TX_HDR_CHECK_EN
      check($sformatf("vec%0d_hdr_err", i), hdr_err_o, vecs[i].er);
`endif
    end

    // Continuous valid: ready low once every 33 cycles, 16 headers per period.
    do_reset;
    valid_i = 1'b1;
    head_i  = 2'b01;
    data_i  = 32'hFFFF_FFFF;
    zeros   = 0;
    for (int c = 0; c < 100; c++) begin
      check($sformatf("ready_c%0d", c), ready_o, (c % 33) != 32);
      @(posedge clk); #1;
      if (c == 0) check("first_word", data_o, 32'hFFFF_FFFD);
      if (valid_o) zeros += $countones(~data_o);
      if (c % 33 == 32) begin
        check($sformatf("hdr_count_c%0d", c), zeros, 16);
        zeros = 0;
      end
    end

    // Two periods of indexed blocks with a 3-cycle gap at seq 10 and an
    // idle input during the second flush; rebuild the 66-bit blocks.
    do_reset;
    words.delete();
    bseq = 0;
    beat = 0;
    for (int c = 0; c < 200 && words.size() < 66; c++) begin
      valid_i = !((c >= 10 && c < 13) || (bseq == 32 && beat >= 64));
      head_i  = blk_head(beat / 2);
      data_i  = (beat % 2 == 1) ? blk_hi(beat / 2) : blk_lo(beat / 2);
      exp_v   = (bseq == 32) || valid_i;
      check("stream_ready", ready_o, bseq != 32);
      @(posedge clk); #1;
      check($sformatf("stream_valid_c%0d", c), valid_o, exp_v);
      if (valid_o) words.push_back(data_o);
      if (bseq == 32) begin
        check("flush_word_index", words.size(), 33 * (beat / 32));
        bseq = 0;
      end else if (valid_i) begin
        bseq++;
        beat++;
      end
    end
    check("stream_word_count", words.size(), 66);
    if (words.size() == 66) begin
      for (int g = 0; g < 32; g++) begin
        for (int b = 0; b < 66; b++) begin
          pos    = g * 66 + b;
          got[b] = words[pos / 32][pos % 32];
        end
        exp_blk = {blk_hi(g), blk_lo(g), blk_head(g)};
        check($sformatf("block%0d", g), got, exp_blk);
      end
    end

    // Reset mid-period (seq 17, odd half pending): partial data discarded.
    do_reset;
    valid_i = 1'b1;
    head_i  = 2'b01;
    data_i  = 32'hC3C3_C3C3;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_data",  data_o,  32'h0);
    check("midrst_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    check("midrst_data_hold", data_o, 32'h0);
    reset   = 1'b0;
    head_i  = 2'b10;
    data_i  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("postrst_valid", valid_o, 1'b1);
    check("postrst_head",  data_o[1:0], 2'b10);
    check("postrst_word",  data_o, 32'hFFFF_FFFE);
    valid_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
